// File: rtl/conseq_detect_ctrl.sv
// Round-robin sequencing controller for a serial consecutive-bit detector:
// clears the detector, shifts a frame in MSB first and returns the collected response word.
// Optional frame hit counter enabled by defining CONSEQ_DETECT_CTRL_HITS_EN.
module conseq_detect_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             det_clr_n,
  output logic             det_x,
  input  logic             det_y,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result
`ifdef CONSEQ_DETECT_CTRL_HITS_EN
  ,
  output logic [7:0]       hits
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] result_r;
  logic             rr_r;
  logic             id_r;
  logic             done_r;
  logic             done_id_r;
  logic             win_s;
`ifdef CONSEQ_DETECT_CTRL_HITS_EN
  logic [7:0]       hits_r;
`endif

  // Arbitration: a lone requester always wins, otherwise the round-robin pointer decides
  always_comb begin
    win_s = 1'b0;
    case (req)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11:   win_s = rr_r;
      default: win_s = 1'b0;
    endcase
  end

  // Sequencer state, shift/collect datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      shift_r   <= {WIDTH{1'b0}};
      result_r  <= {WIDTH{1'b0}};
      rr_r      <= 1'b0;
      id_r      <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= 1'b0;
`ifdef CONSEQ_DETECT_CTRL_HITS_EN
      hits_r    <= 8'd0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req != 2'b00) begin
            state_r  <= CLEAR;
            id_r     <= win_s;
            rr_r     <= ~win_s;
            shift_r  <= win_s ? data1 : data0;
            result_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
          end
        end
        CLEAR: begin
          state_r <= SHIFT;
        end
        SHIFT: begin
          shift_r <= {shift_r[WIDTH-2:0], 1'b0};
          // det_y lags det_x by one edge, so the first SHIFT cycle has nothing to collect
          if (cnt_r != {CW{1'b0}}) begin
            result_r <= {result_r[WIDTH-2:0], det_y};
          end
          if (cnt_r == LAST) begin
            state_r <= DRAIN;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DRAIN: begin
          result_r  <= {result_r[WIDTH-2:0], det_y};
          state_r   <= DONE;
          done_r    <= 1'b1;
          done_id_r <= id_r;
        end
        DONE: begin
          state_r <= IDLE;
`ifdef CONSEQ_DETECT_CTRL_HITS_EN
          if ((result_r != {WIDTH{1'b0}}) && (hits_r != 8'hFF)) begin
            hits_r <= hits_r + 8'd1;
          end
`endif
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    gnt = 2'b00;
    if (state_r == CLEAR) begin
      gnt = id_r ? 2'b10 : 2'b01;
    end else begin
      gnt = 2'b00;
    end
    busy      = (state_r != IDLE);
    det_x     = (state_r == SHIFT) & shift_r[WIDTH-1];
    det_clr_n = reset_n & (state_r != CLEAR);
  end

  assign done    = done_r;
  assign done_id = done_id_r;
  assign result  = result_r;
`ifdef CONSEQ_DETECT_CTRL_HITS_EN
  assign hits    = hits_r;
`endif

endmodule
